hazard_fwd_unit: RTL and testbench
==================================

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 SHALL have port clk  in  1  single rising-edge clock for all state.
REQ-002 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have ports id_valid in 1, id_rs1 in 5, id_rs2 in 5, id_rd in 5, id_regwrite in 1, id_wbsel in 2  decoded ID-stage instruction.
REQ-004 SHALL have ports id_asel in 1, id_bsel in 1 (1 = PC/imm operand), id_store in 1 (rs2 is store data).
REQ-005 SHALL have port ex_redirect  in  1  taken branch/jump resolved in EX.
REQ-006 SHALL have ports fwd_a out 2, fwd_b out 2  registered EX-stage operand selects: 00 none, 01 WB writeback data, 10 MEM ALU result.
REQ-007 SHALL have ports stall out 1 (hold PC and IF/ID), bubble out 1 (zero ID/EX controls), flush out 1 (kill IF/ID).
REQ-008 SHALL have port perf_stalls out 32, perf_flushes out 32 when HAZARD_PERF_EN is defined.

Function
REQ-009 SHALL keep shadow records {valid, rd, regwrite, wbsel} for EX and MEM stages, advancing ID->EX->MEM on every clock.
REQ-010 SHALL treat a stage as producer of register r only if valid, regwrite=1, rd=r, r!=0.
REQ-011 SHALL evaluate operand A only when id_asel=0 and operand B only when id_bsel=0; otherwise the select SHALL be 00.
REQ-012 SHALL set next fwd for a used operand to 10 if EX shadow produces it with wbsel=01 (ALU).
REQ-013 SHALL assert stall and bubble combinationally if EX shadow produces a used operand with wbsel!=01 (load or PC+4).
REQ-014 SHALL otherwise set next fwd to 01 if MEM shadow produces the operand; else 00; EX match wins over MEM.
REQ-015 SHALL assert stall and bubble when id_store=1 and rs2 is produced by EX or MEM shadow; register file is write-first for WB.
REQ-016 SHALL on stall load a bubble (valid=0, fwd 00) into EX shadow while IF/ID holds; single stall cycle resolves each load-use case.
REQ-017 SHALL on ex_redirect assert flush and bubble, load EX shadow invalid, and suppress stall; redirect wins over stall same cycle.
REQ-018 SHALL ignore all hazards when id_valid=0 (no stall, fwd 00).
REQ-019 SHALL register fwd_a/fwd_b so they are valid the cycle the consumer occupies EX (latency 1 from ID decision).

Reset
REQ-020 SHALL on rst_n low clear both shadow valids, fwd_a, fwd_b to 00, and perf counters to 0, independent of clk.
REQ-021 SHALL drive stall, bubble, flush 0 while in reset and in the first cycle after release unless ex_redirect is high.

Configuration
REQ-022 SHALL with HAZARD_PERF_EN defined count cycles with stall=1 and with flush=1 in 32-bit saturating counters (hold at 32'hFFFFFFFF).
REQ-023 SHALL without HAZARD_PERF_EN omit perf ports and counter logic; hazard behaviour identical.

Structure
REQ-024 SHALL take WBSel encodings (WB_DMEM 00, WB_ALU 01, WB_PC4 10) and forward encodings (FWD_NONE 00, FWD_WB 01, FWD_MEM 10) from shared package riscv_pkg.
REQ-025 SHALL place the saturating counter in sub-module hazard_perf_ctr, instantiated twice under HAZARD_PERF_EN.

Verification
REQ-026 SHALL cover: add x5 then add x6,x5,x1 back-to-back -> fwd_a=10 in consumer EX cycle, no stall.
REQ-027 SHALL cover: lw x5 then sub x7,x2,x5 -> stall=1,bubble=1 one cycle, then fwd_b=01; perf_stalls=1.
REQ-028 SHALL cover: addi x0 producer then use of x0 -> fwd 00; auipc-style id_asel=1 with rs1 match -> fwd_a=00.
REQ-029 SHALL cover: load-use hazard and ex_redirect same cycle -> flush=1, stall=0, EX shadow invalid.
REQ-030 SHALL cover: rst_n low mid-stall -> fwd 00, stall 0 immediately; perf counter preset near 32'hFFFFFFFF saturates.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_pkg
//  Purpose  : Shared pipeline encodings for the RISC-V core: write-back
//             source selects, EX-stage operand forward selects, and the
//             shadow record the hazard unit keeps for in-flight instructions.
//  Revision : 1.0  initial release
// ============================================================================
package riscv_pkg;

  // Write-back source select
  localparam logic [1:0] WB_DMEM  = 2'b00;
  localparam logic [1:0] WB_ALU   = 2'b01;
  localparam logic [1:0] WB_PC4   = 2'b10;

  // EX-stage operand forward select
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  // Minimal view of an in-flight instruction, enough to detect producers
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic [1:0] wbsel;
  } shadow_t;

  // True when the shadowed instruction will write register r (x0 never counts)
  function automatic logic produces(input shadow_t s, input logic [4:0] r);
    return s.valid && s.regwrite && (s.rd == r) && (r != 5'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_perf_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_perf_ctr
//  Purpose  : Saturating event counter; holds at all-ones once reached.
//  Ports    : clk    - rising-edge clock
//             rst_n  - asynchronous active-low reset, clears count
//             inc    - count one event this cycle
//             count  - current count value
//  Revision : 1.0  initial release
// ============================================================================
module hazard_perf_ctr #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_fwd_unit
//  Purpose  : Data-hazard detection and operand forwarding for a 5-stage
//             pipeline. Tracks shadow copies of the EX and MEM instructions,
//             decides the forward selects for the instruction in ID (applied
//             one cycle later when it reaches EX), and raises stall/bubble on
//             load-use and store-data hazards and flush/bubble on redirects.
//  Ports    : clk, rst_n                    - clock, async active-low reset
//             id_*                          - decoded ID-stage instruction
//             ex_redirect                   - taken branch/jump from EX
//             fwd_a, fwd_b                  - registered EX operand selects
//             stall, bubble, flush          - pipeline control
//             perf_stalls, perf_flushes     - only with HAZARD_PERF_EN
//  Config   : define HAZARD_PERF_EN to add saturating stall/flush counters.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_fwd_unit
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_regwrite,
  input  logic [1:0]  id_wbsel,
  input  logic        id_asel,
  input  logic        id_bsel,
  input  logic        id_store,
  input  logic        ex_redirect,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        stall,
  output logic        bubble,
  output logic        flush
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stalls,
  output logic [31:0] perf_flushes
`endif
);

  shadow_t    ex_q, ex_d;
  shadow_t    mem_q, mem_d;
  logic [1:0] fwd_a_q, fwd_a_d;
  logic [1:0] fwd_b_q, fwd_b_d;

  logic use_a, use_b;
  logic ex_a, ex_b, mem_a, mem_b;
  logic load_use, store_haz, stall_int;

  always_comb begin
    // Operands sourced from PC/imm never need forwarding
    use_a = id_valid && !id_asel;
    use_b = id_valid && !id_bsel;

    ex_a  = produces(ex_q, id_rs1);
    ex_b  = produces(ex_q, id_rs2);
    mem_a = produces(mem_q, id_rs1);
    mem_b = produces(mem_q, id_rs2);

    // Only ALU results exist at the end of EX; loads and PC+4 must wait
    load_use = (use_a && ex_a && (ex_q.wbsel != WB_ALU)) ||
               (use_b && ex_b && (ex_q.wbsel != WB_ALU));

    // Store data is read from the register file, not the forward muxes, so
    // any pending writer of rs2 must retire first (WB is write-first)
    store_haz = id_valid && id_store && (ex_b || mem_b);

    // A redirect kills the ID instruction, so its hazards are moot
    stall_int = (load_use || store_haz) && !ex_redirect;

    fwd_a_d = FWD_NONE;
    fwd_b_d = FWD_NONE;
    if (!stall_int && !ex_redirect) begin
      if (use_a) begin
        if (ex_a)       fwd_a_d = FWD_MEM;
        else if (mem_a) fwd_a_d = FWD_WB;
      end
      if (use_b) begin
        if (ex_b)       fwd_b_d = FWD_MEM;
        else if (mem_b) fwd_b_d = FWD_WB;
      end
    end

    mem_d = ex_q;
    ex_d  = '0;
    if (id_valid && !stall_int && !ex_redirect) begin
      ex_d.valid    = 1'b1;
      ex_d.rd       = id_rd;
      ex_d.regwrite = id_regwrite;
      ex_d.wbsel    = id_wbsel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      fwd_a_q <= FWD_NONE;
      fwd_b_q <= FWD_NONE;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  // Gate with rst_n so a redirect seen while held in reset stays silent
  assign stall  = stall_int && rst_n;
  assign flush  = ex_redirect && rst_n;
  assign bubble = stall || flush;
  assign fwd_a  = fwd_a_q;
  assign fwd_b  = fwd_b_q;

`ifdef HAZARD_PERF_EN
  hazard_perf_ctr #(.WIDTH(32)) u_stall_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall),
    .count (perf_stalls)
  );

  hazard_perf_ctr #(.WIDTH(32)) u_flush_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush),
    .count (perf_flushes)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_hazard_fwd_unit
//  Purpose  : Self-checking bench for hazard_fwd_unit: directed pipeline
//             scenarios followed by randomized instruction streams, compared
//             against an instruction-level pipeline model. Also exercises a
//             narrow hazard_perf_ctr to reach saturation quickly.
//  Config   : perf ports checked when HAZARD_PERF_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_fwd_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_regwrite, id_asel, id_bsel, id_store, ex_redirect;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [1:0]  id_wbsel;
  logic [1:0]  fwd_a, fwd_b;
  logic        stall, bubble, flush;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stalls, perf_flushes;
`endif

  hazard_fwd_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_wbsel    (id_wbsel),
    .id_asel     (id_asel),
    .id_bsel     (id_bsel),
    .id_store    (id_store),
    .ex_redirect (ex_redirect),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall       (stall),
    .bubble      (bubble),
    .flush       (flush)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stalls (perf_stalls),
    .perf_flushes(perf_flushes)
`endif
  );

  // Narrow counter instance so saturation is reachable in a few cycles
  logic       ctr_rst_n;
  logic       ctr_inc;
  logic [3:0] ctr_count;

  hazard_perf_ctr #(.WIDTH(4)) u_ctr (
    .clk   (clk),
    .rst_n (ctr_rst_n),
    .inc   (ctr_inc),
    .count (ctr_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model: one entry per in-flight instruction
  typedef struct {
    bit valid;
    int rd;
    bit rw;
    int wb;
  } instr_t;

  instr_t      pipe[2];   // [0] = instruction in EX, [1] = instruction in MEM
  int          m_fwd_a, m_fwd_b;
  logic [31:0] m_stalls, m_flushes;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit writes(input instr_t i, input int r);
    return i.valid && i.rw && (i.rd == r) && (r != 0);
  endfunction

  // Where a used operand must come from when the ID instruction reaches EX
  function automatic int source(input bit used, input int r);
    if (!used)             return 0;
    if (writes(pipe[0], r)) return 2;
    if (writes(pipe[1], r)) return 1;
    return 0;
  endfunction

  task automatic model_eval(output bit st, output bit fl, output int nfa, output int nfb);
    bit a_used, b_used, hz;
    a_used = id_valid && !id_asel;
    b_used = id_valid && !id_bsel;
    hz = 1'b0;
    if (a_used && writes(pipe[0], int'(id_rs1)) && pipe[0].wb != 1) hz = 1'b1;
    if (b_used && writes(pipe[0], int'(id_rs2)) && pipe[0].wb != 1) hz = 1'b1;
    if (id_valid && id_store &&
        (writes(pipe[0], int'(id_rs2)) || writes(pipe[1], int'(id_rs2)))) hz = 1'b1;
    fl  = ex_redirect;
    st  = hz && !fl;
    nfa = (st || fl) ? 0 : source(a_used, int'(id_rs1));
    nfb = (st || fl) ? 0 : source(b_used, int'(id_rs2));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      pipe[i].valid = 1'b0; pipe[i].rd = 0; pipe[i].rw = 1'b0; pipe[i].wb = 0;
    end
    m_fwd_a = 0; m_fwd_b = 0;
    m_stalls = 32'd0; m_flushes = 32'd0;
  endtask

  task automatic drive(input bit v, input int rs1, input int rs2, input int rd,
                       input bit rw, input int wb, input bit asel, input bit bsel,
                       input bit st, input bit redir);
    id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
    id_regwrite = rw; id_wbsel = 2'(wb); id_asel = asel; id_bsel = bsel;
    id_store = st; ex_redirect = redir;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Check outputs against the model, then advance one clock (negedge to negedge)
  task automatic cycle();
    bit st, fl;
    int nfa, nfb;
    instr_t nx;
    #1;
    model_eval(st, fl, nfa, nfb);
    check("stall", {31'd0, stall}, {31'd0, st});
    check("bubble", {31'd0, bubble}, {31'd0, st | fl});
    check("flush", {31'd0, flush}, {31'd0, fl});
    check("fwd_a", {30'd0, fwd_a}, 32'(m_fwd_a));
    check("fwd_b", {30'd0, fwd_b}, 32'(m_fwd_b));
`ifdef HAZARD_PERF_EN
    check("perf_stalls", perf_stalls, m_stalls);
    check("perf_flushes", perf_flushes, m_flushes);
`endif
    nx.valid = id_valid && !st && !fl;
    nx.rd = int'(id_rd); nx.rw = id_regwrite; nx.wb = int'(id_wbsel);
    @(posedge clk);
    pipe[1] = pipe[0];
    pipe[0] = nx;
    m_fwd_a = nfa;
    m_fwd_b = nfb;
    if (st && m_stalls != 32'hFFFF_FFFF)  m_stalls++;
    if (fl && m_flushes != 32'hFFFF_FFFF) m_flushes++;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cnt;
    ctr_rst_n = 1'b0;
    ctr_inc   = 1'b0;
    model_reset();

    // ---------------- reset behaviour, redirect asserted while in reset
    rst_n = 1'b0;
    drive(1, 1, 2, 3, 1, 1, 0, 0, 0, 1);
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_bubble", {31'd0, bubble}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_fwd_a", {30'd0, fwd_a}, 32'd0);
    check("rst_fwd_b", {30'd0, fwd_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nop();
    cycle();

    // ---------------- ALU back-to-back: add x5 ; add x6,x5,x1
    drive(1, 1, 2, 5, 1, 1, 0, 0, 0, 0);
    cycle();
    drive(1, 5, 1, 6, 1, 1, 0, 0, 0, 0);
    #1 check("alu_nostall", {31'd0, stall}, 32'd0);
    cycle();
    nop();
    #1 check("alu_fwd_a", {30'd0, fwd_a}, 32'd2);
    cycle();

    // ---------------- load-use: lw x5 ; sub x7,x2,x5
    drive(1, 2, 0, 5, 1, 0, 0, 1, 0, 0);
    cycle();
    drive(1, 2, 5, 7, 1, 1, 0, 0, 0, 0);
    #1 check("lu_stall", {31'd0, stall}, 32'd1);
    check("lu_bubble", {31'd0, bubble}, 32'd1);
    cycle();
    #1 check("lu_release", {31'd0, stall}, 32'd0);
    cycle();
    nop();
    #1 check("lu_fwd_b", {30'd0, fwd_b}, 32'd1);
`ifdef HAZARD_PERF_EN
    check("lu_perf_stalls", perf_stalls, 32'd1);
`endif
    cycle();

    // ---------------- x0 is never forwarded
    drive(1, 1, 0, 0, 1, 1, 0, 1, 0, 0);
    cycle();
    drive(1, 0, 0, 8, 1, 1, 0, 0, 0, 0);
    cycle();
    nop();
    #1 check("x0_fwd_a", {30'd0, fwd_a}, 32'd0);
    check("x0_fwd_b", {30'd0, fwd_b}, 32'd0);
    cycle();

    // ---------------- PC-relative operand A ignores an rs1 match
    drive(1, 1, 2, 7, 1, 1, 0, 0, 0, 0);
    cycle();
    drive(1, 7, 3, 9, 1, 1, 1, 1, 0, 0);
    cycle();
    nop();
    #1 check("asel_fwd_a", {30'd0, fwd_a}, 32'd0);
    cycle();

    // ---------------- load-use coinciding with redirect
    drive(1, 2, 0, 5, 1, 0, 0, 1, 0, 0);
    cycle();
    drive(1, 1, 5, 7, 1, 1, 0, 0, 0, 1);
    #1 check("redir_flush", {31'd0, flush}, 32'd1);
    check("redir_stall", {31'd0, stall}, 32'd0);
    check("redir_bubble", {31'd0, bubble}, 32'd1);
    cycle();
    drive(1, 1, 5, 7, 1, 1, 0, 0, 0, 0);
    #1 check("redir_ex_invalid", {31'd0, stall}, 32'd0);
    cycle();
    nop();
    #1 check("redir_fwd_b", {30'd0, fwd_b}, 32'd1);
`ifdef HAZARD_PERF_EN
    check("redir_perf_flushes", perf_flushes, 32'd1);
`endif
    cycle();

    // ---------------- reset asserted in the middle of a stall
    drive(1, 1, 2, 3, 1, 1, 0, 0, 0, 0);
    cycle();
    drive(1, 3, 0, 5, 1, 0, 0, 1, 0, 0);
    cycle();
    drive(1, 5, 0, 6, 1, 1, 0, 0, 0, 0);
    #1 check("mid_stall", {31'd0, stall}, 32'd1);
    check("mid_fwd_a", {30'd0, fwd_a}, 32'd2);
    rst_n = 1'b0;
    ex_redirect = 1'b1;
    #1 check("mid_rst_stall", {31'd0, stall}, 32'd0);
    check("mid_rst_bubble", {31'd0, bubble}, 32'd0);
    check("mid_rst_flush", {31'd0, flush}, 32'd0);
    check("mid_rst_fwd_a", {30'd0, fwd_a}, 32'd0);
    check("mid_rst_fwd_b", {30'd0, fwd_b}, 32'd0);
`ifdef HAZARD_PERF_EN
    check("mid_rst_perf", perf_stalls, 32'd0);
`endif
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    drive(1, 5, 0, 6, 1, 1, 0, 0, 0, 0);
    cycle();

    // ---------------- randomized instruction stream
    for (int n = 0; n < 600; n++) begin
      drive(($urandom % 8) != 0,
            int'($urandom % 4), int'($urandom % 4), int'($urandom % 4),
            $urandom % 2, int'($urandom % 3),
            ($urandom % 4) == 0, ($urandom % 3) == 0,
            ($urandom % 5) == 0, ($urandom % 10) == 0);
      cycle();
    end

    // ---------------- saturating counter, 4-bit instance
    ctr_rst_n = 1'b1;
    exp_cnt = 0;
    for (int n = 0; n < 24; n++) begin
      ctr_inc = (n % 7) != 3;
      @(posedge clk);
      if (ctr_inc && exp_cnt < 15) exp_cnt++;
      @(negedge clk);
      check("ctr_count", {28'd0, ctr_count}, 32'(exp_cnt));
    end
    check("ctr_saturated", {28'd0, ctr_count}, 32'd15);
    ctr_rst_n = 1'b0;
    #1 check("ctr_async_clear", {28'd0, ctr_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
